cria_pkts_header: RTL and testbench



---
 rtl/cria_pkts_header.sv | 229 ++++++++++++++++++++++
 tb/tb_cria_pkts_header.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cria_pkts_header.sv
// Header generator for event-report packets: supplies the 7-word NetFPGA
// module header + Ethernet/IPv4/UDP header and hosts the addressing
// configuration, enable bit and sent-packet counter on the UDP register ring.
module cria_pkts_header #(
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned NUM_WORDS_PAYLOAD   = 20,
  parameter int unsigned HEADER_LENGTH       = 7,
  parameter int unsigned UDP_REG_SRC_WIDTH   = 2,
  parameter int unsigned UDP_REG_ADDR_WIDTH  = 23,
  parameter int unsigned CPCI_NF2_DATA_WIDTH = 32,
  parameter logic [UDP_REG_ADDR_WIDTH-5:0] BLOCK_TAG = '0
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,

  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,

  input  logic [2:0]                     header_word_number,
  input  logic                           evt_pkt_sent,
  output logic [DATA_WIDTH-1:0]          header_data,
  output logic [7:0]                     header_ctrl,
  output logic                           enable
);

  localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam logic [15:0] UDP_LEN  = 16'(14 + 8 * NUM_WORDS_PAYLOAD);
  localparam logic [15:0] IP_LEN   = 16'(34 + 8 * NUM_WORDS_PAYLOAD);
  localparam logic [15:0] BYTE_LEN = 16'(48 + 8 * NUM_WORDS_PAYLOAD);
  localparam logic [15:0] WORD_LEN = 16'(6 + NUM_WORDS_PAYLOAD);

  // Register state
  logic [15:0] dst_mac_hi_q, dst_mac_hi_d;
  logic [31:0] dst_mac_lo_q, dst_mac_lo_d;
  logic [15:0] src_mac_hi_q, src_mac_hi_d;
  logic [31:0] src_mac_lo_q, src_mac_lo_d;
  logic [31:0] src_ip_q,     src_ip_d;
  logic [31:0] dst_ip_q,     dst_ip_d;
  logic [31:0] udp_ports_q,  udp_ports_d;
  logic [15:0] out_port_q,   out_port_d;
  logic        enable_q,     enable_d;
  logic [31:0] seq_q,        seq_d;

  // Ring output state
  logic                           reg_req_q,     reg_req_d;
  logic                           reg_ack_q,     reg_ack_d;
  logic                           reg_rd_wr_L_q, reg_rd_wr_L_d;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_q,    reg_addr_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_q,    reg_data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_q,     reg_src_d;

  logic        tag_match;
  logic        hit;
  logic [3:0]  offset;
  logic [31:0] rd_val;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [19:0] csum_sum;
  logic [16:0] csum_fold1;
  logic [16:0] csum_fold2;
  logic [15:0] ip_csum;
  logic [63:0] word;
  logic [7:0]  ctrl;

  assign tag_match = (reg_addr_in[UDP_REG_ADDR_WIDTH-1:4] == BLOCK_TAG);
  assign hit       = reg_req_in & ~reg_ack_in & tag_match;
  assign offset    = reg_addr_in[3:0];
  assign dst_mac   = {dst_mac_hi_q, dst_mac_lo_q};
  assign src_mac   = {src_mac_hi_q, src_mac_lo_q};

  // Register read mux, unused upper bits read as zero
  always_comb begin
    rd_val = 32'hDEADBEEF;
    case (offset)
      4'd0: rd_val = {16'h0000, dst_mac_hi_q};
      4'd1: rd_val = dst_mac_lo_q;
      4'd2: rd_val = {16'h0000, src_mac_hi_q};
      4'd3: rd_val = src_mac_lo_q;
      4'd4: rd_val = src_ip_q;
      4'd5: rd_val = dst_ip_q;
      4'd6: rd_val = udp_ports_q;
      4'd7: rd_val = {16'h0000, out_port_q};
      4'd8: rd_val = {31'd0, enable_q};
      4'd9: rd_val = seq_q;
      default: rd_val = 32'hDEADBEEF;
    endcase
  end

  // Register writes and sent-packet counter; a PKT_COUNT write beats a same-cycle increment
  always_comb begin
    dst_mac_hi_d = dst_mac_hi_q;
    dst_mac_lo_d = dst_mac_lo_q;
    src_mac_hi_d = src_mac_hi_q;
    src_mac_lo_d = src_mac_lo_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    udp_ports_d  = udp_ports_q;
    out_port_d   = out_port_q;
    enable_d     = enable_q;
    seq_d        = seq_q + 32'(evt_pkt_sent);
    if (hit && !reg_rd_wr_L_in) begin
      case (offset)
        4'd0: dst_mac_hi_d = reg_data_in[15:0];
        4'd1: dst_mac_lo_d = reg_data_in[31:0];
        4'd2: src_mac_hi_d = reg_data_in[15:0];
        4'd3: src_mac_lo_d = reg_data_in[31:0];
        4'd4: src_ip_d     = reg_data_in[31:0];
        4'd5: dst_ip_d     = reg_data_in[31:0];
        4'd6: udp_ports_d  = reg_data_in[31:0];
        4'd7: out_port_d   = reg_data_in[15:0];
        4'd8: enable_d     = reg_data_in[0];
        4'd9: seq_d        = '0;
        default: ;
      endcase
    end
  end

  // Ring forwarding with ack/read-data substitution on a local hit
  always_comb begin
    reg_req_d     = reg_req_in;
    reg_ack_d     = reg_ack_in;
    reg_rd_wr_L_d = reg_rd_wr_L_in;
    reg_addr_d    = reg_addr_in;
    reg_data_d    = reg_data_in;
    reg_src_d     = reg_src_in;
    if (hit) begin
      reg_ack_d = 1'b1;
      if (reg_rd_wr_L_in) reg_data_d = CPCI_NF2_DATA_WIDTH'(rd_val);
    end
  end

  // IPv4 header checksum over the ten halfwords with the checksum field as zero
  always_comb begin
    csum_sum = 20'h04500 + 20'(IP_LEN) + 20'h00000 + 20'h04000 + 20'h04011
             + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
             + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
    csum_fold1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum_fold2 = 17'(csum_fold1[15:0]) + 17'(csum_fold1[16]);
    ip_csum    = ~csum_fold2[15:0];
  end

  // Header word select
  always_comb begin
    word = '0;
    ctrl = 8'h00;
    case (header_word_number)
      3'd0: begin
        word = {out_port_q, WORD_LEN, 16'h0000, BYTE_LEN};
        ctrl = IO_QUEUE_STAGE_NUM;
      end
      3'd1: word = {dst_mac, src_mac[47:32]};
      3'd2: word = {src_mac[31:0], 16'h0800, 8'h45, 8'h00};
      3'd3: word = {IP_LEN, 16'h0000, 16'h4000, 8'h40, 8'h11};
      3'd4: word = {ip_csum, src_ip_q, dst_ip_q[31:16]};
      3'd5: word = {dst_ip_q[15:0], udp_ports_q, UDP_LEN};
      3'd6: word = {16'h0000, seq_q, 16'h0000};
      default: begin
        word = '0;
        ctrl = 8'h00;
      end
    endcase
    if (32'(header_word_number) >= HEADER_LENGTH) begin
      word = '0;
      ctrl = 8'h00;
    end
  end

  assign header_data = DATA_WIDTH'(word);
  assign header_ctrl = ctrl;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_mac_hi_q  <= 16'hFFFF;
      dst_mac_lo_q  <= 32'hFFFFFFFF;
      src_mac_hi_q  <= 16'h004E;
      src_mac_lo_q  <= 32'h46324300;
      src_ip_q      <= 32'hC0A80001;
      dst_ip_q      <= 32'hC0A80002;
      udp_ports_q   <= 32'h1F901F91;
      out_port_q    <= 16'h0001;
      enable_q      <= 1'b0;
      seq_q         <= '0;
      reg_req_q     <= 1'b0;
      reg_ack_q     <= 1'b0;
      reg_rd_wr_L_q <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      reg_src_q     <= '0;
    end else begin
      dst_mac_hi_q  <= dst_mac_hi_d;
      dst_mac_lo_q  <= dst_mac_lo_d;
      src_mac_hi_q  <= src_mac_hi_d;
      src_mac_lo_q  <= src_mac_lo_d;
      src_ip_q      <= src_ip_d;
      dst_ip_q      <= dst_ip_d;
      udp_ports_q   <= udp_ports_d;
      out_port_q    <= out_port_d;
      enable_q      <= enable_d;
      seq_q         <= seq_d;
      reg_req_q     <= reg_req_d;
      reg_ack_q     <= reg_ack_d;
      reg_rd_wr_L_q <= reg_rd_wr_L_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      reg_src_q     <= reg_src_d;
    end
  end

  assign reg_req_out     = reg_req_q;
  assign reg_ack_out     = reg_ack_q;
  assign reg_rd_wr_L_out = reg_rd_wr_L_q;
  assign reg_addr_out    = reg_addr_q;
  assign reg_data_out    = reg_data_q;
  assign reg_src_out     = reg_src_q;
  assign enable          = enable_q;

endmodule

// File: tb/tb_cria_pkts_header.sv
// Directed bench for cria_pkts_header: header words, checksum, sequence
// counter, register ring access/pass-through and mid-operation reset.
module tb_cria_pkts_header;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic [2:0]  header_word_number;
  logic        evt_pkt_sent;
  logic [63:0] header_data;
  logic [7:0]  header_ctrl;
  logic        enable;

  int vectors = 0;
  int miscompares = 0;

  cria_pkts_header #(
    .DATA_WIDTH(64),
    .NUM_WORDS_PAYLOAD(20),
    .HEADER_LENGTH(7),
    .UDP_REG_SRC_WIDTH(2),
    .UDP_REG_ADDR_WIDTH(23),
    .CPCI_NF2_DATA_WIDTH(32),
    .BLOCK_TAG(19'd0)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .header_word_number(header_word_number), .evt_pkt_sent(evt_pkt_sent),
    .header_data(header_data), .header_ctrl(header_ctrl), .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ring transaction presented for a single cycle; outputs checked after return
  task automatic ring(input logic rd_wr_L, input logic ack, input logic [22:0] addr,
                      input logic [31:0] data, input logic [1:0] src);
    reg_req_in = 1'b1; reg_ack_in = ack; reg_rd_wr_L_in = rd_wr_L;
    reg_addr_in = addr; reg_data_in = data; reg_src_in = src;
    tick();
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic word(input logic [2:0] n, output logic [63:0] d, output logic [7:0] c);
    header_word_number = n;
    #1;
    d = header_data;
    c = header_ctrl;
  endtask

  // Reference IPv4 checksum: halfword list summed with end-around carry
  function automatic logic [15:0] model_csum(input logic [31:0] sip, input logic [31:0] dip);
    logic [15:0] hw [10];
    logic [31:0] s;
    hw = '{16'h4500, 16'd194, 16'h0000, 16'h4000, 16'h4011, 16'h0000,
           sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
    s = 0;
    for (int i = 0; i < 10; i++) begin
      s = s + 32'(hw[i]);
      if (s > 32'hFFFF) s = (s & 32'hFFFF) + 1;
    end
    return ~s[15:0];
  endfunction

  logic [63:0] d;
  logic [7:0]  c;
  logic [63:0] exp_words [8];

  initial begin
    reset = 1'b1; evt_pkt_sent = 1'b0; header_word_number = '0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_req_out", 64'(reg_req_out), 64'd0);
    chk("rst_ack_out", 64'(reg_ack_out), 64'd0);
    chk("rst_data_out", 64'(reg_data_out), 64'd0);
    chk("rst_enable", 64'(enable), 64'd0);

    // Header after reset
    exp_words = '{64'h0001_001A_0000_00D0, 64'hFFFF_FFFF_FFFF_004E,
                  64'h4632_4300_0800_4500, 64'h00C2_0000_4000_4011,
                  64'hB8D7_C0A8_0001_C0A8, 64'h0002_1F90_1F91_00AE,
                  64'h0, 64'h0};
    for (int i = 0; i < 8; i++) begin
      word(3'(i), d, c);
      chk($sformatf("rst_word%0d", i), d, exp_words[i]);
      chk($sformatf("rst_ctrl%0d", i), 64'(c), (i == 0) ? 64'hFF : 64'h00);
    end
    word(3'd4, d, c);
    chk("csum_rst_model", 64'(d[63:48]), 64'(model_csum(32'hC0A80001, 32'hC0A80002)));

    // SRC_IP write updates checksum and field
    ring(1'b0, 1'b0, 23'h000004, 32'h0A000001, 2'd1);
    chk("wr_srcip_ack", 64'(reg_ack_out), 64'd1);
    word(3'd4, d, c);
    chk("srcip_word4", d, 64'h6F80_0A00_0001_C0A8);
    chk("csum_srcip_model", 64'(d[63:48]), 64'(model_csum(32'h0A000001, 32'hC0A80002)));

    // Sequence counter: three pulses
    for (int i = 0; i < 3; i++) begin
      evt_pkt_sent = 1'b1; tick();
      evt_pkt_sent = 1'b0; tick();
    end
    word(3'd6, d, c);
    chk("seq3_word6", d, 64'h0000_0000_0003_0000);
    ring(1'b1, 1'b0, 23'h000009, 32'h0, 2'd0);
    chk("seq3_rd_ack", 64'(reg_ack_out), 64'd1);
    chk("seq3_rd_data", 64'(reg_data_out), 64'd3);

    // PKT_COUNT write coincident with a pulse: clear wins
    evt_pkt_sent = 1'b1;
    ring(1'b0, 1'b0, 23'h000009, 32'h12345678, 2'd0);
    evt_pkt_sent = 1'b0;
    word(3'd6, d, c);
    chk("seq_clr_word6", d, 64'h0);
    ring(1'b1, 1'b0, 23'h000009, 32'h0, 2'd0);
    chk("seq_clr_rd", 64'(reg_data_out), 64'd0);

    // DST_IP write and read-back
    ring(1'b0, 1'b0, 23'h000005, 32'h01020304, 2'd3);
    chk("dstip_wr_ack", 64'(reg_ack_out), 64'd1);
    chk("dstip_wr_data_fwd", 64'(reg_data_out), 64'h01020304);
    chk("dstip_wr_src_fwd", 64'(reg_src_out), 64'd3);
    word(3'd5, d, c);
    chk("dstip_word5_hi", 64'(d[63:48]), 64'h0304);
    word(3'd4, d, c);
    chk("dstip_word4_lo", 64'(d[15:0]), 64'h0102);
    ring(1'b1, 1'b0, 23'h000005, 32'h0, 2'd2);
    chk("dstip_rd_data", 64'(reg_data_out), 64'h01020304);
    chk("dstip_rd_addr", 64'(reg_addr_out), 64'h000005);
    chk("dstip_rd_rdwr", 64'(reg_rd_wr_L_out), 64'd1);

    // Reserved offset and zero-extended narrow register
    ring(1'b1, 1'b0, 23'h00000C, 32'h0, 2'd0);
    chk("rsvd_rd", 64'(reg_data_out), 64'hDEADBEEF);
    ring(1'b1, 1'b0, 23'h000000, 32'h0, 2'd0);
    chk("dmachi_rd", 64'(reg_data_out), 64'h0000FFFF);

    // Pass-through: non-matching tag
    ring(1'b0, 1'b0, 23'h000014, 32'h55AA55AA, 2'd2);
    chk("pt_tag_req", 64'(reg_req_out), 64'd1);
    chk("pt_tag_ack", 64'(reg_ack_out), 64'd0);
    chk("pt_tag_addr", 64'(reg_addr_out), 64'h000014);
    chk("pt_tag_data", 64'(reg_data_out), 64'h55AA55AA);
    chk("pt_tag_src", 64'(reg_src_out), 64'd2);
    word(3'd4, d, c);
    chk("pt_tag_srcip_kept", 64'(d[47:16]), 64'h0A000001);

    // Pass-through: already acked, matching tag
    ring(1'b0, 1'b1, 23'h000005, 32'h99999999, 2'd1);
    chk("pt_ack_ack", 64'(reg_ack_out), 64'd1);
    chk("pt_ack_data", 64'(reg_data_out), 64'h99999999);
    word(3'd5, d, c);
    chk("pt_ack_dstip_kept", 64'(d[63:48]), 64'h0304);
    tick();
    chk("idle_req_out", 64'(reg_req_out), 64'd0);

    // Mid-operation reset
    ring(1'b0, 1'b0, 23'h000008, 32'h00000001, 2'd0);
    chk("en_set", 64'(enable), 64'd1);
    evt_pkt_sent = 1'b1; tick(); evt_pkt_sent = 1'b0;
    word(3'd6, d, c);
    chk("pre_rst_seq", d, 64'h0000_0000_0001_0000);
    reset = 1'b1;
    reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b1; reg_addr_in = 23'h000008;
    tick();
    reg_req_in = 1'b0; reg_rd_wr_L_in = 1'b0; reg_addr_in = '0;
    chk("mid_rst_enable", 64'(enable), 64'd0);
    chk("mid_rst_ack", 64'(reg_ack_out), 64'd0);
    word(3'd6, d, c);
    chk("mid_rst_seq", d, 64'h0);
    word(3'd4, d, c);
    chk("mid_rst_word4", d, 64'hB8D7_C0A8_0001_C0A8);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
